pipeline_hazard_controller: RTL and testbench

Sequential hazard controller for the five-stage RISC-V pipeline. It consumes the decoded control bits carried down the pipeline (`memoryReadEnable`, `registerWriteEnable`, `pcUpdate`) plus register addresses and a memory handshake. It drives stall and flush for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences load-use stalls, taken-branch/jump flushes and multi-cycle data-memory waits, with a timeout watchdog.

---
 rtl/pipeline_hazard_controller_pkg.sv | 13 +
 rtl/pipeline_hazard_controller_if.sv | 63 ++++++
 rtl/pipeline_hazard_controller_load_use_detector.sv | 23 ++
 rtl/pipeline_hazard_controller.sv | 164 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro used by this slice: HAZARD_PERF_COUNTERS_EN.
package defaultParametersPkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hazardStateType;

  localparam logic [4:0] ZERO_REGISTER = 5'd0;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline <-> hazard controller bundle: decoded ID/EX/MEM fields in, stall/flush/redirect out.
// With HAZARD_PERF_COUNTERS_EN defined the bundle also carries stallCount and flushCount.
interface pipeline_hazard_controller_if;
  import defaultParametersPkg::*;

  logic [4:0]     idRs1;
  logic [4:0]     idRs2;
  logic           idUsesRs1;
  logic           idUsesRs2;
  logic [4:0]     exRd;
  logic           exMemoryReadEnable;
  logic           exRegisterWriteEnable;
  logic           exPcUpdate;
  logic           exBranchTaken;
  // Memory handshake: an access is in flight while memRequest is high; it completes
  // in the cycle memReady is high (ready in the request cycle means zero wait).
  logic           memRequest;
  logic           memReady;

  logic           pcStall;
  logic           ifIdStall;
  logic           idExStall;
  logic           exMemStall;
  logic           ifIdFlush;
  logic           idExFlush;
  logic           memWbFlush;
  logic           pcRedirect;
  logic           memTimeoutError;
  hazardStateType debugState;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0]    stallCount;
  logic [31:0]    flushCount;
`endif

`ifdef HAZARD_PERF_COUNTERS_EN
  modport master (
    output idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemoryReadEnable,
           exRegisterWriteEnable, exPcUpdate, exBranchTaken, memRequest, memReady,
    input  pcStall, ifIdStall, idExStall, exMemStall, ifIdFlush, idExFlush,
           memWbFlush, pcRedirect, memTimeoutError, debugState, stallCount, flushCount
  );
  modport slave (
    input  idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemoryReadEnable,
           exRegisterWriteEnable, exPcUpdate, exBranchTaken, memRequest, memReady,
    output pcStall, ifIdStall, idExStall, exMemStall, ifIdFlush, idExFlush,
           memWbFlush, pcRedirect, memTimeoutError, debugState, stallCount, flushCount
  );
`else
  modport master (
    output idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemoryReadEnable,
           exRegisterWriteEnable, exPcUpdate, exBranchTaken, memRequest, memReady,
    input  pcStall, ifIdStall, idExStall, exMemStall, ifIdFlush, idExFlush,
           memWbFlush, pcRedirect, memTimeoutError, debugState
  );
  modport slave (
    input  idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemoryReadEnable,
           exRegisterWriteEnable, exPcUpdate, exBranchTaken, memRequest, memReady,
    output pcStall, ifIdStall, idExStall, exMemStall, ifIdFlush, idExFlush,
           memWbFlush, pcRedirect, memTimeoutError, debugState
  );
`endif

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use hazard detect: a load in EX whose rd feeds a source read in ID.
module loadUseDetector
  import defaultParametersPkg::*;
(
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic       idUsesRs1,
  input  logic       idUsesRs2,
  input  logic [4:0] exRd,
  input  logic       exMemoryReadEnable,
  output logic       loadUseHazard
);

  logic rs1Match;
  logic rs2Match;

  assign rs1Match = idUsesRs1 && (idRs1 == exRd);
  assign rs2Match = idUsesRs2 && (idRs2 == exRd);

  // x0 is hardwired to zero, so a load targeting it never produces a value to wait for.
  assign loadUseHazard = exMemoryReadEnable && (exRd != ZERO_REGISTER) && (rs1Match || rs2Match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline hazard sequencer: load-use stalls, taken-redirect flushes, memory waits.
// HAZARD_PERF_COUNTERS_EN adds wrapping stall/flush cycle counters.
module pipeline_hazard_controller
  import defaultParametersPkg::*;
#(
  parameter int LOAD_USE_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT           = 255
) (
  input logic                          clock,
  input logic                          reset,
  pipeline_hazard_controller_if.slave  hz
);

  localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [1:0]        LOAD_REMAIN = 2'(LOAD_USE_STALL_CYCLES - 1);

  hazardStateType    state, stateNext;
  hazardStateType    savedState, savedStateNext;
  hazardStateType    resumeState;
  logic [1:0]        stallRemain, stallRemainNext;
  logic [1:0]        savedRemain, savedRemainNext;
  logic [1:0]        resumeRemain;
  logic [WAIT_W-1:0] waitCount, waitCountNext;
  logic              timeoutError, timeoutErrorNext;

  logic loadUseHazard;
  logic memWait;
  logic taken;

  logic pcStallInt, ifIdStallInt, idExStallInt, exMemStallInt;
  logic ifIdFlushInt, idExFlushInt, memWbFlushInt, pcRedirectInt;
  logic pcStallOut, ifIdFlushOut;

  loadUseDetector u_loadUseDetector (
    .idRs1              (hz.idRs1),
    .idRs2              (hz.idRs2),
    .idUsesRs1          (hz.idUsesRs1),
    .idUsesRs2          (hz.idUsesRs2),
    .exRd               (hz.exRd),
    .exMemoryReadEnable (hz.exMemoryReadEnable),
    .loadUseHazard      (loadUseHazard)
  );

  assign memWait = hz.memRequest && !hz.memReady;
  // Jumps arrive with exBranchTaken already set, so one term covers both.
  assign taken   = hz.exPcUpdate && hz.exBranchTaken;

  always_comb begin
    pcStallInt       = 1'b0;
    ifIdStallInt     = 1'b0;
    idExStallInt     = 1'b0;
    exMemStallInt    = 1'b0;
    ifIdFlushInt     = 1'b0;
    idExFlushInt     = 1'b0;
    memWbFlushInt    = 1'b0;
    pcRedirectInt    = 1'b0;
    stateNext        = state;
    savedStateNext   = savedState;
    stallRemainNext  = stallRemain;
    savedRemainNext  = savedRemain;
    waitCountNext    = '0;
    timeoutErrorNext = timeoutError;
    // Leaving MEM_WAIT this cycle behaves as if the saved state were current.
    resumeState      = (state == MEM_WAIT) ? savedState  : state;
    resumeRemain     = (state == MEM_WAIT) ? savedRemain : stallRemain;

    if (memWait) begin
      pcStallInt    = 1'b1;
      ifIdStallInt  = 1'b1;
      idExStallInt  = 1'b1;
      exMemStallInt = 1'b1;
      memWbFlushInt = 1'b1;
      stateNext     = MEM_WAIT;
      if (state != MEM_WAIT) begin
        savedStateNext  = state;
        savedRemainNext = stallRemain;
      end
      waitCountNext = (waitCount == WAIT_LIMIT) ? waitCount : waitCount + 1'b1;
      if (waitCountNext == WAIT_LIMIT) begin
        timeoutErrorNext = 1'b1;
      end
    end else if (taken) begin
      pcRedirectInt   = 1'b1;
      ifIdFlushInt    = 1'b1;
      idExFlushInt    = 1'b1;
      stallRemainNext = 2'd0;
      stateNext       = RUN;
    end else if (resumeState == LOAD_STALL) begin
      pcStallInt   = 1'b1;
      ifIdStallInt = 1'b1;
      idExFlushInt = 1'b1;
      if (resumeRemain <= 2'd1) begin
        stallRemainNext = 2'd0;
        stateNext       = RUN;
      end else begin
        stallRemainNext = resumeRemain - 2'd1;
        stateNext       = LOAD_STALL;
      end
    end else if (loadUseHazard) begin
      pcStallInt   = 1'b1;
      ifIdStallInt = 1'b1;
      idExFlushInt = 1'b1;
      stateNext    = RUN;
      if (LOAD_USE_STALL_CYCLES > 1) begin
        stallRemainNext = LOAD_REMAIN;
        stateNext       = LOAD_STALL;
      end
    end else begin
      stateNext = RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      savedState   <= RUN;
      stallRemain  <= 2'd0;
      savedRemain  <= 2'd0;
      waitCount    <= '0;
      timeoutError <= 1'b0;
    end else begin
      state        <= stateNext;
      savedState   <= savedStateNext;
      stallRemain  <= stallRemainNext;
      savedRemain  <= savedRemainNext;
      waitCount    <= waitCountNext;
      timeoutError <= timeoutErrorNext;
    end
  end

  assign pcStallOut   = pcStallInt & ~reset;
  assign ifIdFlushOut = ifIdFlushInt & ~reset;

  assign hz.pcStall         = pcStallOut;
  assign hz.ifIdStall       = ifIdStallInt & ~reset;
  assign hz.idExStall       = idExStallInt & ~reset;
  assign hz.exMemStall      = exMemStallInt & ~reset;
  assign hz.ifIdFlush       = ifIdFlushOut;
  assign hz.idExFlush       = idExFlushInt & ~reset;
  assign hz.memWbFlush      = memWbFlushInt & ~reset;
  assign hz.pcRedirect      = pcRedirectInt & ~reset;
  assign hz.memTimeoutError = timeoutError;
  assign hz.debugState      = state;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stallCountReg;
  logic [31:0] flushCountReg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stallCountReg <= 32'd0;
      flushCountReg <= 32'd0;
    end else begin
      if (pcStallOut)   stallCountReg <= stallCountReg + 32'd1;
      if (ifIdFlushOut) flushCountReg <= flushCountReg + 32'd1;
    end
  end

  assign hz.stallCount = stallCountReg;
  assign hz.flushCount = flushCountReg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: two controllers (1 and 2 load-use bubbles, timeout 4) share one stimulus stream.
module tb_pipeline_hazard_controller;
  import defaultParametersPkg::*;

  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110001000;
  localparam logic [8:0] TK   = 9'b000011010;
  localparam logic [8:0] MW   = 9'b111100100;
  localparam logic [8:0] ER   = 9'b000000001;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipeline_hazard_controller_if aIf ();
  pipeline_hazard_controller_if bIf ();

  assign bIf.idRs1                 = aIf.idRs1;
  assign bIf.idRs2                 = aIf.idRs2;
  assign bIf.idUsesRs1             = aIf.idUsesRs1;
  assign bIf.idUsesRs2             = aIf.idUsesRs2;
  assign bIf.exRd                  = aIf.exRd;
  assign bIf.exMemoryReadEnable    = aIf.exMemoryReadEnable;
  assign bIf.exRegisterWriteEnable = aIf.exRegisterWriteEnable;
  assign bIf.exPcUpdate            = aIf.exPcUpdate;
  assign bIf.exBranchTaken         = aIf.exBranchTaken;
  assign bIf.memRequest            = aIf.memRequest;
  assign bIf.memReady              = aIf.memReady;

  pipeline_hazard_controller #(.LOAD_USE_STALL_CYCLES(1), .MEM_TIMEOUT(4)) dutA (
    .clock (clock),
    .reset (reset),
    .hz    (aIf)
  );

  pipeline_hazard_controller #(.LOAD_USE_STALL_CYCLES(2), .MEM_TIMEOUT(4)) dutB (
    .clock (clock),
    .reset (reset),
    .hz    (bIf)
  );

  logic [10:0] obsA;
  logic [10:0] obsB;
  assign obsA = {aIf.pcStall, aIf.ifIdStall, aIf.idExStall, aIf.exMemStall, aIf.ifIdFlush,
                 aIf.idExFlush, aIf.memWbFlush, aIf.pcRedirect, aIf.memTimeoutError, aIf.debugState};
  assign obsB = {bIf.pcStall, bIf.ifIdStall, bIf.idExStall, bIf.exMemStall, bIf.ifIdFlush,
                 bIf.idExFlush, bIf.memWbFlush, bIf.pcRedirect, bIf.memTimeoutError, bIf.debugState};

  logic [10:0] expA_q[$];
  logic [10:0] expB_q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] expStallA = 32'd0;
  logic [31:0] expFlushA = 32'd0;
  logic [31:0] expStallB = 32'd0;
  logic [31:0] expFlushB = 32'd0;

  task automatic setIn(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic pcu, input logic tkn,
                       input logic mreq, input logic mrdy);
    aIf.idRs1                 = rs1;
    aIf.idRs2                 = rs2;
    aIf.idUsesRs1             = u1;
    aIf.idUsesRs2             = u2;
    aIf.exRd                  = rd;
    aIf.exMemoryReadEnable    = ld;
    aIf.exRegisterWriteEnable = ld;
    aIf.exPcUpdate            = pcu;
    aIf.exBranchTaken         = tkn;
    aIf.memRequest            = mreq;
    aIf.memReady              = mrdy;
  endtask

  task automatic idle();
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // lw x5 in EX, add reading x5 through rs2 in ID.
  task automatic loadUse(input logic pcu, input logic tkn, input logic mreq, input logic mrdy);
    setIn(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, pcu, tkn, mreq, mrdy);
  endtask

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [8:0] oa, input logic [1:0] sa,
                      input logic [8:0] ob, input logic [1:0] sb);
    expA_q.push_back({oa, sa});
    expB_q.push_back({ob, sb});
    @(negedge clock);
    compare({tag, "/A"}, {21'd0, obsA}, {21'd0, expA_q.pop_front()});
    compare({tag, "/B"}, {21'd0, obsB}, {21'd0, expB_q.pop_front()});
`ifdef HAZARD_PERF_COUNTERS_EN
    compare({tag, "/A.stallCount"}, aIf.stallCount, expStallA);
    compare({tag, "/A.flushCount"}, aIf.flushCount, expFlushA);
    compare({tag, "/B.stallCount"}, bIf.stallCount, expStallB);
    compare({tag, "/B.flushCount"}, bIf.flushCount, expFlushB);
    if (oa[8]) expStallA++;
    if (oa[4]) expFlushA++;
    if (ob[8]) expStallB++;
    if (ob[4]) expFlushB++;
`endif
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    loadUse(1'b0, 1'b0, 1'b0, 1'b0);
    step("resetForcesZero", NONE, RUN, NONE, RUN);
    reset = 1'b0;
    idle();
    step("idle", NONE, RUN, NONE, RUN);

    // Load-use penalty: 1 bubble for A, 2 for B.
    loadUse(1'b0, 1'b0, 1'b0, 1'b0);
    step("loadUse1", LU, RUN, LU, RUN);
    idle();
    step("loadUse2", NONE, RUN, LU, LOAD_STALL);
    step("loadUseDone", NONE, RUN, NONE, RUN);

    setIn(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rdZeroNoHazard", NONE, RUN, NONE, RUN);
    setIn(5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("unusedSourcesNoHazard", NONE, RUN, NONE, RUN);
    setIn(5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("loadUseRs1", LU, RUN, LU, RUN);

    // Taken branch cancels B's pending second bubble.
    loadUse(1'b1, 1'b1, 1'b0, 1'b0);
    step("takenCancelsStall", TK, RUN, TK, LOAD_STALL);
    idle();
    step("afterCancel", NONE, RUN, NONE, RUN);
    loadUse(1'b1, 1'b1, 1'b0, 1'b0);
    step("takenOverLoadUse", TK, RUN, TK, RUN);
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("branchNotTaken", NONE, RUN, NONE, RUN);

    // Three wait cycles, released in the ready cycle.
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("memWait1", MW, RUN, MW, RUN);
    step("memWait2", MW, MEM_WAIT, MW, MEM_WAIT);
    step("memWait3", MW, MEM_WAIT, MW, MEM_WAIT);
    aIf.memReady = 1'b1;
    step("memReadyRelease", NONE, MEM_WAIT, NONE, MEM_WAIT);
    idle();
    step("afterRelease", NONE, RUN, NONE, RUN);
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("zeroWaitAccess", NONE, RUN, NONE, RUN);

    // Load stall interrupted by a memory wait resumes with its remaining bubble.
    loadUse(1'b0, 1'b0, 1'b0, 1'b0);
    step("stallBeforeWait", LU, RUN, LU, RUN);
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("waitInStall1", MW, RUN, MW, LOAD_STALL);
    step("waitInStall2", MW, MEM_WAIT, MW, MEM_WAIT);
    aIf.memReady = 1'b1;
    step("stallResumes", NONE, MEM_WAIT, LU, MEM_WAIT);
    idle();
    step("stallResumeDone", NONE, RUN, NONE, RUN);

    // Memory wait beats load-use; load-use is re-evaluated on release.
    loadUse(1'b0, 1'b0, 1'b1, 1'b0);
    step("waitOverLoadUse", MW, RUN, MW, RUN);
    loadUse(1'b0, 1'b0, 1'b1, 1'b1);
    step("loadUseOnRelease", LU, MEM_WAIT, LU, MEM_WAIT);
    idle();
    step("loadUseOnRelease2", NONE, RUN, LU, LOAD_STALL);
    step("loadUseOnReleaseDone", NONE, RUN, NONE, RUN);

    // Taken branch re-evaluated on release.
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("waitOverTaken", MW, RUN, MW, RUN);
    aIf.memReady = 1'b1;
    step("takenOnRelease", TK, MEM_WAIT, TK, MEM_WAIT);
    idle();
    step("takenOnReleaseDone", NONE, RUN, NONE, RUN);

    // Timeout after 4 wait cycles; the flag is sticky.
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("timeoutWait1", MW, RUN, MW, RUN);
    step("timeoutWait2", MW, MEM_WAIT, MW, MEM_WAIT);
    step("timeoutWait3", MW, MEM_WAIT, MW, MEM_WAIT);
    step("timeoutWait4", MW, MEM_WAIT, MW, MEM_WAIT);
    step("timeoutSet", MW | ER, MEM_WAIT, MW | ER, MEM_WAIT);
    step("timeoutFrozen", MW | ER, MEM_WAIT, MW | ER, MEM_WAIT);
    aIf.memReady = 1'b1;
    step("timeoutRelease", ER, MEM_WAIT, ER, MEM_WAIT);
    idle();
    step("timeoutSticky1", ER, RUN, ER, RUN);
    step("timeoutSticky2", ER, RUN, ER, RUN);

    // Reset asserted mid-wait clears everything without a clock edge.
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("preResetWait1", MW | ER, RUN, MW | ER, RUN);
    step("preResetWait2", MW | ER, MEM_WAIT, MW | ER, MEM_WAIT);
    reset = 1'b1;
    expStallA = 32'd0;
    expFlushA = 32'd0;
    expStallB = 32'd0;
    expFlushB = 32'd0;
    step("resetMidWait", NONE, RUN, NONE, RUN);
    reset = 1'b0;
    idle();
    step("postReset", NONE, RUN, NONE, RUN);

    loadUse(1'b0, 1'b0, 1'b0, 1'b0);
    step("countLoadUse", LU, RUN, LU, RUN);
    idle();
    step("countLoadUse2", NONE, RUN, LU, LOAD_STALL);
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("countTaken", TK, RUN, TK, RUN);
    idle();
    step("countIdle1", NONE, RUN, NONE, RUN);
    step("countIdle2", NONE, RUN, NONE, RUN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
